// File: rtl/asrv32_uart_tx_if.sv
// Data-bus port bundle for the console/exit responder.
// The master drives requests; the slave returns read data and a one-cycle ack.
interface asrv32_uart_tx_if;
    logic        i_stb_data;
    logic        i_wr_en;
    logic [31:0] i_data_addr;
    logic [31:0] i_data_in;
    logic [3:0]  i_wr_mask;
    logic [31:0] o_data_out;
    logic        o_ack_data;

    modport master (
        output i_stb_data, i_wr_en, i_data_addr, i_data_in, i_wr_mask,
        input  o_data_out, o_ack_data
    );

    modport slave (
        input  i_stb_data, i_wr_en, i_data_addr, i_data_in, i_wr_mask,
        output o_data_out, o_ack_data
    );
endinterface

// File: rtl/asrv32_uart_tx.sv
// Memory-mapped console: TX FIFO feeding an 8N1 serialiser, plus a sticky EXIT/halt register.
// Registers: 0 TXDATA, 1 STATUS, 2 EXIT, 3 reserved (offset = addr[3:2]).
module asrv32_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    asrv32_uart_tx_if.slave        bus,
    output logic                   o_uart_tx,
    output logic                   o_halt,
    output logic [31:0]            o_exit_code
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_TC = BW'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state, w_state_nx;
    logic [BW-1:0] r_baud, w_baud_nx;
    logic [2:0]    r_bit, w_bit_nx;
    logic [7:0]    r_shift, w_shift_nx;
    logic          w_pop;
    logic          w_baud_tc;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic          r_ack;
    logic [31:0]   r_data_out;
    logic          r_halt;
    logic [31:0]   r_exit;

    logic          w_sel, w_rd, w_wr;
    logic [1:0]    w_off;
    logic          w_push_req, w_push_ok, w_ovf_set, w_status_rd, w_exit_wr;
    logic [31:0]   w_status, w_rdata;
    logic          w_unused_addr;

    assign w_sel       = bus.i_stb_data && (bus.i_data_addr[31:4] == BASE_ADDR[31:4]);
    assign w_rd        = w_sel && !bus.i_wr_en;
    assign w_wr        = w_sel && bus.i_wr_en;
    assign w_off       = bus.i_data_addr[3:2];
    assign w_unused_addr = ^bus.i_data_addr[1:0];

    // No bypass: acceptance depends only on the count at the start of the cycle.
    assign w_push_req  = w_wr && (w_off == 2'd0) && bus.i_wr_mask[0];
    assign w_push_ok   = w_push_req && (r_count != DEPTH_C);
    assign w_ovf_set   = w_push_req && !w_push_ok;
    assign w_status_rd = w_rd && (w_off == 2'd1);
    assign w_exit_wr   = w_wr && (w_off == 2'd2) && (bus.i_wr_mask != 4'h0);

    always_comb begin
        w_status            = '0;
        w_status[0]         = (r_count == DEPTH_C);
        w_status[1]         = (r_count == '0);
        w_status[2]         = (r_state != S_IDLE);
        w_status[3]         = r_ovf;
        w_status[8 +: CW]   = r_count;
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            2'd1:    w_rdata = w_status;
            2'd2:    w_rdata = r_exit;
            default: w_rdata = '0;
        endcase
    end

    assign w_baud_tc = (r_baud == BAUD_TC);

    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_pop      = 1'b0;
        o_uart_tx  = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop      = 1'b1;
                    w_shift_nx = r_mem[r_rptr];
                    w_baud_nx  = '0;
                    w_bit_nx   = '0;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                o_uart_tx = 1'b0;
                w_baud_nx = w_baud_tc ? '0 : r_baud + 1'b1;
                if (w_baud_tc) w_state_nx = S_DATA;
            end
            S_DATA: begin
                o_uart_tx = r_shift[0];
                w_baud_nx = w_baud_tc ? '0 : r_baud + 1'b1;
                if (w_baud_tc) begin
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    w_bit_nx   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_nx = S_STOP;
                end
            end
            S_STOP: begin
                w_baud_nx = w_baud_tc ? '0 : r_baud + 1'b1;
                if (w_baud_tc) w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_ack      <= 1'b0;
            r_data_out <= '0;
            r_halt     <= 1'b0;
            r_exit     <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_baud     <= w_baud_nx;
            r_bit      <= w_bit_nx;
            r_shift    <= w_shift_nx;
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            r_count    <= r_count + CW'(w_push_ok) - CW'(w_pop);
            // A drop in the same cycle as a STATUS read keeps overflow set.
            if (w_ovf_set)        r_ovf <= 1'b1;
            else if (w_status_rd) r_ovf <= 1'b0;
            r_ack      <= w_sel;
            r_data_out <= w_rd ? w_rdata : '0;
            if (w_exit_wr && !r_halt) begin
                r_halt <= 1'b1;
                r_exit <= bus.i_data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= bus.i_data_in[7:0];
    end

    assign bus.o_ack_data = r_ack;
    assign bus.o_data_out = r_data_out;
    assign o_halt         = r_halt;
    assign o_exit_code    = r_exit;
endmodule

// File: tb/tb_asrv32_uart_tx.sv
// Bench for asrv32_uart_tx: register-access vector table, frame monitor with byte scoreboard,
// and directed sequences for back-to-back frames, overflow, EXIT and mid-frame reset.
module tb_asrv32_uart_tx;
    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam logic [31:0] BASE       = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        o_uart_tx;
    logic        o_halt;
    logic [31:0] o_exit_code;

    asrv32_uart_tx_if bus ();

    asrv32_uart_tx #(
        .BASE_ADDR  (BASE),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_uart_tx   (o_uart_tx),
        .o_halt      (o_halt),
        .o_exit_code (o_exit_code)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  sb[$];
    int unsigned starts[$];
    logic        mon_busy = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        exp_ack;
        logic        chk;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic wr, input logic [31:0] d, input logic [3:0] m);
        bus.i_stb_data  = 1'b1;
        bus.i_wr_en     = wr;
        bus.i_data_addr = a;
        bus.i_data_in   = d;
        bus.i_wr_mask   = m;
    endtask

    task automatic idle_bus();
        bus.i_stb_data  = 1'b0;
        bus.i_wr_en     = 1'b0;
        bus.i_data_addr = '0;
        bus.i_data_in   = '0;
        bus.i_wr_mask   = '0;
    endtask

    // One request, then one idle cycle; checks the ack is a single-cycle pulse.
    task automatic access(input string name, input logic [31:0] a, input logic wr, input logic [31:0] d,
                          input logic [3:0] m, input logic exp_ack, output logic [31:0] rd);
        drive(a, wr, d, m);
        step();
        check({name, "_ack"}, 32'(bus.o_ack_data), 32'(exp_ack));
        rd = bus.o_data_out;
        idle_bus();
        step();
        check({name, "_ack_drop"}, 32'(bus.o_ack_data), 32'd0);
    endtask

    task automatic wait_drain(input string name, input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((sb.size() != 0 || mon_busy) && n < budget) begin
            step();
            n++;
        end
        check({name, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_starts(input string name, input int unsigned cnt, input int unsigned budget);
        int unsigned n;
        n = 0;
        while (starts.size() < cnt && n < budget) begin
            step();
            n++;
        end
        check({name, "_started"}, 32'(starts.size() >= cnt), 32'd1);
    endtask

    // Frame receiver: checks every cycle of start, data and stop bits against the 8N1 shape.
    initial begin : monitor
        logic [7:0]  mb;
        logic        mok;
        logic        mab;
        logic [7:0]  exp;
        int unsigned idx;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && o_uart_tx === 1'b0) begin
                mon_busy = 1'b1;
                starts.push_back(cyc);
                mok = 1'b1;
                mab = 1'b0;
                mb  = '0;
                for (int k = 0; k < 10 * CLK_DIV; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        mab = 1'b1;
                        break;
                    end
                    idx = k / CLK_DIV;
                    if (idx == 0) begin
                        if (o_uart_tx !== 1'b0) mok = 1'b0;
                    end else if (idx == 9) begin
                        if (o_uart_tx !== 1'b1) mok = 1'b0;
                    end else if (k % CLK_DIV == 0) begin
                        mb[idx-1] = o_uart_tx;
                    end else if (o_uart_tx !== mb[idx-1]) begin
                        mok = 1'b0;
                    end
                end
                if (!mab) begin
                    if (sb.size() == 0) begin
                        check("frame_unexpected", 32'(sb.size()), 32'd1);
                    end else begin
                        exp = sb.pop_front();
                        check("frame", {23'b0, mok, mb}, {23'b0, 1'b1, exp});
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int unsigned c0;

        vecs[0] = '{32'h8000_0004, 1'b0, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0000_0002};
        vecs[1] = '{32'h8000_0000, 1'b0, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[2] = '{32'h8000_0008, 1'b0, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[3] = '{32'h8000_000C, 1'b0, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[4] = '{32'h8000_000C, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{32'h8000_0000, 1'b1, 32'h0000_0077, 4'hE, 1'b1, 1'b0, 32'h0};
        vecs[6] = '{32'h8000_0010, 1'b1, 32'h0000_0099, 4'h1, 1'b0, 1'b0, 32'h0};
        vecs[7] = '{32'h7FFF_FFF4, 1'b0, 32'h0,         4'h0, 1'b0, 1'b0, 32'h0};
        vecs[8] = '{32'h8000_0007, 1'b0, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0000_0002};
        vecs[9] = '{32'h8000_0008, 1'b1, 32'h0000_0005, 4'h0, 1'b1, 1'b0, 32'h0};

        idle_bus();
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_tx",      32'(o_uart_tx),      32'd1);
        check("rst_ack",     32'(bus.o_ack_data), 32'd0);
        check("rst_dout",    bus.o_data_out,      32'd0);
        check("rst_halt",    32'(o_halt),         32'd0);
        check("rst_exit",    o_exit_code,         32'd0);
        rst_n = 1'b1;
        step();

        // Register map and decode edges
        for (int i = 0; i < 10; i++) begin
            access($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].mask,
                   vecs[i].exp_ack, rd);
            if (vecs[i].chk) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
        end
        check("mask0_exit_no_halt", 32'(o_halt), 32'd0);
        repeat (20) step();
        check("decode_no_frame", 32'(starts.size()), 32'd0);

        // Single frame 0x55
        starts.delete();
        sb.push_back(8'h55);
        c0 = cyc;
        access("tx55", BASE, 1'b1, 32'h0000_0055, 4'h1, 1'b1, rd);
        wait_starts("tx55", 1, 20);
        check("tx55_latency", starts[0] - c0, 32'd2);
        repeat (10) step();
        access("tx55_st_mid", BASE + 32'h4, 1'b0, 32'h0, 4'h0, 1'b1, rd);
        check("tx55_st_mid_rd", rd, 32'h0000_0006);
        wait_drain("tx55", 200);
        repeat (2) step();
        access("tx55_st_end", BASE + 32'h4, 1'b0, 32'h0, 4'h0, 1'b1, rd);
        check("tx55_st_end_rd", rd, 32'h0000_0002);

        // Back-to-back pushes on consecutive cycles
        starts.delete();
        for (int i = 0; i < 3; i++) begin
            sb.push_back(8'h41 + 8'(i));
            drive(BASE, 1'b1, 32'h41 + 32'(i), 4'h1);
            step();
            check($sformatf("b2b%0d_ack", i), 32'(bus.o_ack_data), 32'd1);
        end
        idle_bus();
        wait_starts("b2b1", 1, 20);
        repeat (4) step();
        access("b2b_st1", BASE + 32'h4, 1'b0, 32'h0, 4'h0, 1'b1, rd);
        check("b2b_st1_rd", rd, 32'h0000_0204);
        wait_starts("b2b2", 2, 100);
        repeat (4) step();
        access("b2b_st2", BASE + 32'h4, 1'b0, 32'h0, 4'h0, 1'b1, rd);
        check("b2b_st2_rd", rd, 32'h0000_0104);
        wait_starts("b2b3", 3, 100);
        repeat (4) step();
        access("b2b_st3", BASE + 32'h4, 1'b0, 32'h0, 4'h0, 1'b1, rd);
        check("b2b_st3_rd", rd, 32'h0000_0006);
        wait_drain("b2b", 300);
        check("b2b_gap01", starts[1] - starts[0], 32'(10 * CLK_DIV + 1));
        check("b2b_gap12", starts[2] - starts[1], 32'(10 * CLK_DIV + 1));

        // Overflow: 10 pushes; the first is popped on the second cycle, so 9 fit and 1 drops
        repeat (3) step();
        starts.delete();
        for (int i = 0; i < 10; i++) begin
            if (i < 9) sb.push_back(8'h10 + 8'(i));
            drive(BASE, 1'b1, 32'h10 + 32'(i), 4'h1);
            step();
            check($sformatf("ovf_push%0d_ack", i), 32'(bus.o_ack_data), 32'd1);
        end
        idle_bus();
        access("ovf_st1", BASE + 32'h4, 1'b0, 32'h0, 4'h0, 1'b1, rd);
        check("ovf_st1_rd", rd, 32'h0000_080D);
        access("ovf_st2", BASE + 32'h4, 1'b0, 32'h0, 4'h0, 1'b1, rd);
        check("ovf_st2_rd", rd, 32'h0000_0805);
        wait_drain("ovf", 1000);
        repeat (20) step();
        check("ovf_frames", 32'(starts.size()), 32'd9);

        // EXIT: first write captures, second ignored, FSM keeps running after halt
        drive(BASE + 32'h8, 1'b1, 32'h0000_0000, 4'hF);
        step();
        check("exit1_ack",  32'(bus.o_ack_data), 32'd1);
        check("exit1_halt", 32'(o_halt),         32'd1);
        check("exit1_code", o_exit_code,         32'd0);
        idle_bus();
        step();
        access("exit2", BASE + 32'h8, 1'b1, 32'h0000_0002, 4'hF, 1'b1, rd);
        check("exit2_halt", 32'(o_halt), 32'd1);
        check("exit2_code", o_exit_code, 32'd0);
        access("exit_rd", BASE + 32'h8, 1'b0, 32'h0, 4'h0, 1'b1, rd);
        check("exit_rd_val", rd, 32'd0);
        sb.push_back(8'hC3);
        access("halt_tx", BASE, 1'b1, 32'h0000_00C3, 4'h1, 1'b1, rd);
        wait_drain("halt_tx", 200);

        // Reset during DATA bit 3 with a second byte still queued
        repeat (3) step();
        starts.delete();
        sb.push_back(8'hA5);
        sb.push_back(8'h3C);
        access("rst_p0", BASE, 1'b1, 32'h0000_00A5, 4'h1, 1'b1, rd);
        access("rst_p1", BASE, 1'b1, 32'h0000_003C, 4'h1, 1'b1, rd);
        wait_starts("rst_frame", 1, 20);
        for (int n = 0; n < 40 && cyc < starts[0] + 17; n++) step();
        check("rst_bit3_tx", 32'(o_uart_tx), 32'd0);
        rst_n = 1'b0;
        drive(BASE + 32'h4, 1'b0, 32'h0, 4'h0);
        step();
        check("midrst_tx",   32'(o_uart_tx),      32'd1);
        check("midrst_ack",  32'(bus.o_ack_data), 32'd0);
        check("midrst_halt", 32'(o_halt),         32'd0);
        check("midrst_exit", o_exit_code,         32'd0);
        rst_n = 1'b1;
        idle_bus();
        sb.delete();
        step();
        access("midrst_st", BASE + 32'h4, 1'b0, 32'h0, 4'h0, 1'b1, rd);
        check("midrst_st_rd", rd, 32'h0000_0002);
        repeat (150) step();
        check("midrst_no_frames", 32'(starts.size()), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
